pipo_load_arbiter: RTL and testbench
====================================

Name: pipo_load_arbiter

Overview:
- Round-robin arbiter that shares the 8-bit PIPO load register between NUM_REQ requesters.
- Grants one requester per arbitration, loads that requester's byte into the internal PIPO output register, and records the owner.
- Enforces a programmable idle gap after each load so downstream logic can settle.
- Sits between the requester clients and the consumers of the registered PIPO byte.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, width of each requester's data word and of out.
- GAP, 1, idle cycles inserted after each load; legal range 0..15.
- ID_W, $clog2(NUM_REQ), width of the owner index (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester load request; level, held until granted.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant pulse, combinational, 1 cycle.
- out  output  DATA_W  registered PIPO byte; holds its value between loads.
- out_valid  output  1  registered 1-cycle pulse, high the cycle after a load edge.
- out_owner  output  ID_W  index of the requester whose data is in out.
- busy  output  1  high while in GAP state.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst=1): out=0, out_valid=0, out_owner=0, rr_ptr=0, gap_cnt=0, state=IDLE. gnt=0 while rst=1.
- FSM states: IDLE, GAP.
- IDLE with any req=1: winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - gnt[winner]=1 in the same cycle (Mealy).
  - At the next posedge: out<=req_data[winner], out_owner<=winner, out_valid<=1, rr_ptr<=(winner+1) mod NUM_REQ.
  - If GAP>0: state<=GAP, gap_cnt<=GAP-1. If GAP=0: stay IDLE, so back-to-back grants are possible every cycle.
- IDLE with no req: gnt=0, out_valid<=0, no other state change.
- GAP: gnt=0, busy=1, out_valid<=0.
  - gap_cnt decrements each cycle; when gap_cnt==0, state<=IDLE.
  - GAP cycles occur between the load edge and the next possible grant cycle.
- Load-to-load spacing: with all requests asserted, grants occur every GAP+1 cycles.
- Handshake rules:
  - A requester keeps req and its data stable until it sees gnt.
  - It may deassert req the cycle after gnt; if req stays high it re-enters arbitration.
  - Dropping req before gnt is legal; that requester is simply not granted, and rr_ptr is unchanged.
- Fairness: a requester that holds req continuously is granted within NUM_REQ arbitrations.
- Widths: out_owner is zero-extended to ID_W; the rr_ptr increment wraps modulo NUM_REQ, including non-power-of-2 NUM_REQ.
- Reset mid-GAP or in the cycle of a grant aborts the operation; the load does not occur and all state returns to reset values.
- Invariants: gnt is always one-hot or zero; out changes only on a load edge.

Test Plan:
1. Reset: rst=1 with arbitrary req/data -> gnt=0, out=0x00, out_valid=0, out_owner=0, busy=0. After release with no req, all outputs stay at reset values.
2. Single requester: GAP=1, req[2]=1, data2=0xA5 -> gnt[2] pulses in the cycle req is seen; next cycle out=0xA5, out_owner=2, out_valid=1, busy=1; the cycle after, IDLE and gnt[2] again while req[2] is held.
3. Four-way contention: GAP=1, req=4'b1111, data i=0x10+i -> grant order 0,1,2,3,0 with grants 2 cycles apart; out sequence 0x10, 0x11, 0x12, 0x13.
4. Wrap and skip: GAP=0, after a grant to 3 (rr_ptr=0), req=4'b1010 -> grant 1 then 3 on consecutive cycles, out=data1 then data3 with out_valid high two cycles in a row.
5. Reset mid-GAP: GAP=3, a load of 0x5C completes, then rst pulses during the 2nd GAP cycle -> out=0x00, busy=0 and rr_ptr=0 immediately; the next grant goes to the lowest-index active req.
6. Withdrawn request: GAP=2, req[1] rises then falls during GAP -> no gnt[1], out is unchanged, rr_ptr is unchanged.

Source files
------------

// File: rtl/pipo_load_arbiter_if.sv
// pipo_load_arbiter_if: requester-side request/data bus and registered PIPO output bus.
interface pipo_load_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         out;
  logic                      out_valid;
  logic [ID_W-1:0]           out_owner;
  logic                      busy;
  modport master (output req, req_data, input gnt, out, out_valid, out_owner, busy);
  modport slave  (input req, req_data, output gnt, out, out_valid, out_owner, busy);
endinterface

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter: round-robin arbiter loading one requester byte into a PIPO register,
// followed by a programmable idle gap.
module pipo_load_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int GAP     = 1,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  pipo_load_arbiter_if.slave bus
);
  typedef enum logic {S_IDLE, S_GAP} state_t;
  state_t state_q, state_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, idx;
  logic [DATA_W-1:0] out_q, out_d;
  logic valid_q, valid_d, found;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0] data [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) assign data[i] = bus.req_data[i*DATA_W +: DATA_W];
  always_comb begin
    found = 1'b0;
    win = rr_ptr_q;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gap_cnt_d = gap_cnt_q;
    rr_ptr_d = rr_ptr_q;
    out_d = out_q;
    owner_d = owner_q;
    valid_d = 1'b0;
    gnt = '0;
    if (state_q == S_IDLE) begin
      if (found && !rst) begin
        gnt[win] = 1'b1;
        out_d = data[win];
        owner_d = win;
        valid_d = 1'b1;
        rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
        state_d = (GAP > 0) ? S_GAP : S_IDLE;
        gap_cnt_d = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
      end
    end else begin
      state_d = (gap_cnt_q == 4'd0) ? S_IDLE : S_GAP;
      gap_cnt_d = (gap_cnt_q == 4'd0) ? 4'd0 : gap_cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_cnt_q <= '0;
      rr_ptr_q <= '0;
      out_q <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_cnt_q <= gap_cnt_d;
      rr_ptr_q <= rr_ptr_d;
      out_q <= out_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
    end
  end
  assign bus.gnt = gnt;
  assign bus.out = out_q;
  assign bus.out_valid = valid_q;
  assign bus.out_owner = owner_q;
  assign bus.busy = (state_q == S_GAP);
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// tb_pipo_load_arbiter: four arbiters (GAP=0..3) on shared stimulus, each checked every cycle
// against a queue-free behavioural model, plus directed literal expectations.
module tb_pipo_load_arbiter;
  logic clk, rst;
  logic [3:0] req;
  logic [31:0] req_data;
  logic [3:0] gnt_a [4];
  logic [7:0] out_a [4];
  logic valid_a [4], busy_a [4];
  logic [1:0] owner_a [4];
  int errors = 0, checks = 0;
  int m_ptr [4], m_wait [4], m_owner [4], m_out [4], m_valid [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : u
    pipo_load_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();
    assign bus.req = req;
    assign bus.req_data = req_data;
    pipo_load_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP(g)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign gnt_a[g] = bus.gnt;
    assign out_a[g] = bus.out;
    assign valid_a[g] = bus.out_valid;
    assign owner_a[g] = bus.out_owner;
    assign busy_a[g] = bus.busy;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int mwin(int i);
    if (rst || m_wait[i] > 0) return -1;
    for (int k = 0; k < 4; k++) if (req[(m_ptr[i] + k) % 4]) return (m_ptr[i] + k) % 4;
    return -1;
  endfunction

  task automatic mreset(int i);
    m_ptr[i] = 0; m_wait[i] = 0; m_owner[i] = 0; m_out[i] = 0; m_valid[i] = 0;
  endtask

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      int w;
      if (rst) mreset(i);
      w = mwin(i);
      chk($sformatf("g%0d gnt", i), 32'(gnt_a[i]), (w < 0) ? 32'd0 : 32'd1 << w);
      chk($sformatf("g%0d out", i), 32'(out_a[i]), 32'(m_out[i]));
      chk($sformatf("g%0d out_valid", i), 32'(valid_a[i]), 32'(m_valid[i]));
      chk($sformatf("g%0d out_owner", i), 32'(owner_a[i]), 32'(m_owner[i]));
      chk($sformatf("g%0d busy", i), 32'(busy_a[i]), 32'(m_wait[i] > 0));
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      int w;
      w = mwin(i);
      if (rst) mreset(i);
      else if (m_wait[i] > 0) begin m_wait[i]--; m_valid[i] = 0; end
      else if (w < 0) m_valid[i] = 0;
      else begin
        m_out[i] = int'(req_data[w*8 +: 8]);
        m_owner[i] = w;
        m_valid[i] = 1;
        m_ptr[i] = (w + 1) % 4;
        m_wait[i] = i;
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); endtask
  task automatic rst_pulse(); step(); rst = 1'b1; req = '0; step(); rst = 1'b0; endtask

  initial begin
    rst = 1'b1; req = 4'b1111; req_data = 32'hDEADBEEF;
    look();
    for (int i = 0; i < 4; i++) begin
      chk("rst gnt", 32'(gnt_a[i]), 32'd0);
      chk("rst out", 32'(out_a[i]), 32'd0);
      chk("rst valid", 32'(valid_a[i]), 32'd0);
      chk("rst owner", 32'(owner_a[i]), 32'd0);
      chk("rst busy", 32'(busy_a[i]), 32'd0);
    end
    step(); rst = 1'b0; req = '0;
    repeat (3) step();
    look();
    for (int i = 0; i < 4; i++) chk("idle out", 32'(out_a[i]), 32'd0);
    step(); req = 4'b0100; req_data = 32'h00A50000;
    look(); chk("single gnt", 32'(gnt_a[1]), 32'h4);
    step(); look();
    chk("single out", 32'(out_a[1]), 32'hA5);
    chk("single owner", 32'(owner_a[1]), 32'd2);
    chk("single valid", 32'(valid_a[1]), 32'd1);
    chk("single busy", 32'(busy_a[1]), 32'd1);
    chk("single gap gnt", 32'(gnt_a[1]), 32'd0);
    step(); look(); chk("single regnt", 32'(gnt_a[1]), 32'h4);
    step(); req = '0;
    rst_pulse();
    step(); req = 4'b1111; req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      look(); chk("rr gnt", 32'(gnt_a[1]), 32'd1 << (k % 4));
      step(); look();
      chk("rr out", 32'(out_a[1]), 32'h10 + 32'(k % 4));
      chk("rr owner", 32'(owner_a[1]), 32'(k % 4));
      step();
    end
    req = '0;
    rst_pulse();
    step(); req = 4'b1000; req_data = 32'h44332211;
    look(); chk("wrap gnt3", 32'(gnt_a[0]), 32'h8);
    step(); req = 4'b1010;
    look(); chk("wrap gnt1", 32'(gnt_a[0]), 32'h2);
    step(); look();
    chk("wrap out1", 32'(out_a[0]), 32'h22);
    chk("wrap valid1", 32'(valid_a[0]), 32'd1);
    chk("wrap gnt3b", 32'(gnt_a[0]), 32'h8);
    step(); req = '0; look();
    chk("wrap out3", 32'(out_a[0]), 32'h44);
    chk("wrap valid3", 32'(valid_a[0]), 32'd1);
    chk("wrap owner3", 32'(owner_a[0]), 32'd3);
    rst_pulse();
    step(); req = 4'b0100; req_data = 32'h005C6600;
    look(); chk("midgap gnt", 32'(gnt_a[3]), 32'h4);
    step(); req = '0; look();
    chk("midgap out", 32'(out_a[3]), 32'h5C);
    chk("midgap busy", 32'(busy_a[3]), 32'd1);
    step(); #1; rst = 1'b1; #1;
    chk("async out", 32'(out_a[3]), 32'd0);
    chk("async busy", 32'(busy_a[3]), 32'd0);
    chk("async owner", 32'(owner_a[3]), 32'd0);
    step(); rst = 1'b0; req = 4'b1010;
    look(); chk("post rst gnt", 32'(gnt_a[3]), 32'h2);
    step(); req = '0; look();
    chk("post rst out", 32'(out_a[3]), 32'h66);
    chk("post rst owner", 32'(owner_a[3]), 32'd1);
    rst_pulse();
    step(); req = 4'b0001; req_data = 32'h00000077;
    look(); chk("wd gnt0", 32'(gnt_a[2]), 32'h1);
    step(); req = 4'b0010;
    look(); chk("wd gap1 gnt", 32'(gnt_a[2]), 32'd0);
    step(); req = '0;
    look(); chk("wd gap2 gnt", 32'(gnt_a[2]), 32'd0);
    chk("wd gap2 busy", 32'(busy_a[2]), 32'd1);
    step(); look();
    chk("wd idle busy", 32'(busy_a[2]), 32'd0);
    chk("wd idle out", 32'(out_a[2]), 32'h77);
    chk("wd idle owner", 32'(owner_a[2]), 32'd0);
    step(); req = 4'b0011;
    look(); chk("wd ptr gnt", 32'(gnt_a[2]), 32'h2);
    step(); req = '0;
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
